// File: rtl/uart_frame_pkg.sv
// Shared types, constants and checksum helper for the UART packet framer.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } framer_state_t;

  localparam int unsigned FRAME_LEN_CSUM   = 6;
  localparam int unsigned FRAME_LEN_NOCSUM = 5;

  typedef logic [2:0] byte_idx_t;

  // Two's complement of the modulo-256 payload sum, so payload + checksum == 0 mod 256.
  function automatic logic [7:0] frame_checksum(input logic [7:0]  addr,
                                                input logic [7:0]  mode,
                                                input logic [15:0] data);
    logic [7:0] sum;
    sum = addr + mode + data[15:8] + data[7:0];
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/uart_packet_framer_if.sv
// Byte-stream valid/ready handshake between the framer and the UART transmitter.
interface uart_packet_framer_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_byte,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_packet_framer.sv
// Captures one result packet and serialises it as a fixed-length byte frame followed by an
// inter-frame gap. Optional trailing checksum byte is enabled by defining FRAMER_CHECKSUM_EN.
module uart_packet_framer
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_ready,
  input  logic [7:0]           toPC_address,
  input  logic [7:0]           toPC_mode,
  input  logic [15:0]          toPC_data,
  output logic                 tx_complete,
  uart_packet_framer_if.master tx,
  output logic                 overrun,
  output logic [15:0]          frames_sent
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES == 0) ? '0 : GapW'(GAP_CYCLES - 1);

`ifdef FRAMER_CHECKSUM_EN
  localparam byte_idx_t LastIdx = byte_idx_t'(FRAME_LEN_CSUM - 1);
`else
  localparam byte_idx_t LastIdx = byte_idx_t'(FRAME_LEN_NOCSUM - 1);
`endif

  framer_state_t   state_q, state_d;
  byte_idx_t       idx_q, idx_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      mode_q, mode_d;
  logic [15:0]     data_q, data_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     frames_sent_q, frames_sent_d;
`ifdef FRAMER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Dropping in the capture cycle keeps the arbiter from queuing a second packet behind this one.
  assign tx_complete = (state_q == IDLE) && !data_ready;
  assign overrun     = overrun_q;
  assign frames_sent = frames_sent_q;
  assign tx.tx_valid = (state_q == SEND);

  // Byte mux: selects the frame byte at the current index while sending.
  always_comb begin
    tx.tx_byte = 8'h00;
    if (state_q == SEND) begin
      unique case (idx_q)
        3'd0:    tx.tx_byte = SYNC_BYTE;
        3'd1:    tx.tx_byte = addr_q;
        3'd2:    tx.tx_byte = mode_q;
        3'd3:    tx.tx_byte = data_q[15:8];
        3'd4:    tx.tx_byte = data_q[7:0];
`ifdef FRAMER_CHECKSUM_EN
        3'd5:    tx.tx_byte = csum_q;
`endif
        default: tx.tx_byte = 8'h00;
      endcase
    end
  end

  // Next-state logic: capture, byte sequencing, gap countdown and overrun tracking.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    addr_d        = addr_q;
    mode_d        = mode_q;
    data_d        = data_q;
    overrun_d     = overrun_q;
    frames_sent_d = frames_sent_q;
`ifdef FRAMER_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    if (data_ready && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (data_ready) begin
          addr_d  = toPC_address;
          mode_d  = toPC_mode;
          data_d  = toPC_data;
`ifdef FRAMER_CHECKSUM_EN
          csum_d  = frame_checksum(toPC_address, toPC_mode, toPC_data);
`endif
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          if (idx_q == LastIdx) begin
            idx_d         = '0;
            frames_sent_d = frames_sent_q + 16'd1;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GapLoad;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      gap_q         <= '0;
      addr_q        <= '0;
      mode_q        <= '0;
      data_q        <= '0;
      overrun_q     <= 1'b0;
      frames_sent_q <= '0;
`ifdef FRAMER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      addr_q        <= addr_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      overrun_q     <= overrun_d;
      frames_sent_q <= frames_sent_d;
`ifdef FRAMER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

endmodule
